menu_line_fetcher: RTL

- Scheduler for the read port (port B) of the 2 KB menu overlay RAM.
- Once per scanline it walks the 32x28 text buffer at 0x000–0x37F and fetches each character's glyph row from the 8x8 font at 0x400–0x7FF. The glyph rows go into a 32-byte back line buffer, which is swapped to the front at the next line start.
- Renders a 1-bit overlay pixel for the 256x224 menu display from the front buffer.
- Sits between the video timing generator and the overlay RAM; the menu CPU owns port A.

---
 rtl/menu_line_fetcher.sv | 129 ++++++++++++
 1 files changed

// File: rtl/menu_line_fetcher.sv
// Menu overlay line fetcher: walks the text buffer once per scanline,
// fetches glyph rows into a back line buffer and renders from the front one.
module menu_line_fetcher #(
    parameter logic [10:0] TEXT_BASE = 11'h000,
    parameter logic [10:0] FONT_BASE = 11'h400,
    parameter int          ROWS      = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        line_start,
    input  logic [7:0]  line_y,
    input  logic [7:0]  pix_x,
    output logic        pix_on,
    output logic        busy,
    output logic        overrun,
    output logic        mem_ce,
    output logic [10:0] mem_addr,
    input  logic [7:0]  mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        CHAR,
        GLYPH,
        STORE
    } state_t;

    localparam logic [8:0] LAST_LINE = 9'(ROWS * 8);

    state_t      state;
    logic [7:0]  front [0:31];
    logic [7:0]  back  [0:31];
    logic [4:0]  row;
    logic [4:0]  col;
    logic [2:0]  yrow;
    logic        inv;
    logic [10:0] last_addr;
    logic        blank_line;

    assign blank_line = ({1'b0, line_y} >= LAST_LINE);

    // The glyph address must reach the RAM in the same cycle the character
    // code comes back, so the port B address is decoded from the state.
    always_comb begin
        mem_ce   = 1'b0;
        mem_addr = last_addr;
        if (enable) begin
            unique case (state)
                CHAR: begin
                    mem_ce   = 1'b1;
                    mem_addr = TEXT_BASE + {1'b0, row, col};
                end
                GLYPH: begin
                    mem_ce   = 1'b1;
                    mem_addr = FONT_BASE + {1'b0, mem_dout[6:0], yrow};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            pix_on    <= 1'b0;
            row       <= '0;
            col       <= '0;
            yrow      <= '0;
            inv       <= 1'b0;
            last_addr <= '0;
            for (int i = 0; i < 32; i++) begin
                front[i] <= 8'h00;
                back[i]  <= 8'h00;
            end
        end else begin
            overrun <= 1'b0;
            pix_on  <= enable & front[pix_x[7:3]][pix_x[2:0]];
            if (mem_ce)
                last_addr <= mem_addr;

            if (line_start) begin
                // A half-fetched line is never shown
                overrun <= busy;
                for (int i = 0; i < 32; i++)
                    front[i] <= busy ? 8'h00 : back[i];
                row  <= line_y[7:3];
                yrow <= line_y[2:0];
                col  <= '0;
                if (!enable || blank_line) begin
                    for (int i = 0; i < 32; i++)
                        back[i] <= 8'h00;
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    state <= CHAR;
                    busy  <= 1'b1;
                end
            end else if (busy && !enable) begin
                for (int i = 0; i < 32; i++)
                    back[i] <= 8'h00;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    CHAR: state <= GLYPH;
                    GLYPH: begin
                        inv   <= mem_dout[7];
                        state <= STORE;
                    end
                    STORE: begin
                        back[col] <= mem_dout ^ {8{inv}};
                        if (col == 5'd31) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            col   <= col + 5'd1;
                            state <= CHAR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
